// File: rtl/voice_allocator.sv
// voice_allocator
//   Three-voice note allocator with retrigger, lowest-free allocation,
//   oldest-voice stealing and per-voice stereo pan codes.
//
// Ports
//   clk_in        system clock, rising edge
//   rst_in        asynchronous active-high reset
//   note_valid    note event offered
//   note_ready    event accepted when high together with note_valid
//   note_on       1 = note-on, 0 = note-off
//   note_num      7-bit note number
//   pan_mode      00/11 both, 01 alternate, 10 fixed per voice
//   voice_active  {c, b, a} active bits
//   voice_note_x  note held by voice x (kept after note-off)
//   stereo_x      pan code of voice x: 01 right, 10 left, 11 both, 00 mute
//   steal_pulse   one-cycle pulse when an active voice is reassigned
//
// State   | meaning
// --------+--------------------------------------------------------------
// IDLE    | note_ready high, waiting for an event
// SEARCH  | pick the target voice and sample pan_mode
// COMMIT  | apply the update; outputs change on the edge leaving COMMIT
module voice_allocator #(
  parameter int AGE_W = 8
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       note_valid,
  output logic       note_ready,
  input  logic       note_on,
  input  logic [6:0] note_num,
  input  logic [1:0] pan_mode,
  output logic [2:0] voice_active,
  output logic [6:0] voice_note_a,
  output logic [6:0] voice_note_b,
  output logic [6:0] voice_note_c,
  output logic [1:0] stereo_a,
  output logic [1:0] stereo_b,
  output logic [1:0] stereo_c,
  output logic       steal_pulse
);

  typedef enum logic [1:0] {IDLE, SEARCH, COMMIT} state_t;

  localparam logic [AGE_W-1:0] AGE_MAX = '1;
  localparam logic [AGE_W-1:0] AGE_ONE = {{(AGE_W-1){1'b0}}, 1'b1};

  state_t           state;
  logic [2:0]       active_r;
  logic [6:0]       note_r [3];
  logic [1:0]       pan_r  [3];
  logic [AGE_W-1:0] age_r  [3];
  logic             toggle_r;

  // Latched event and the decision taken in SEARCH
  logic       note_on_q;
  logic [6:0] note_q;
  logic [1:0] tgt_q;
  logic       hit_q;
  logic       steal_q;
  logic [1:0] code_q;

  logic       hit;
  logic [1:0] hit_idx;
  logic       free_any;
  logic [1:0] free_idx;
  logic [1:0] old_idx;
  logic [1:0] tgt;
  logic [1:0] code;

  // Descending scans leave the lowest matching index in hit_idx/free_idx;
  // the strict compare keeps the lowest index on equal ages.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = 2'd0;
    free_any = 1'b0;
    free_idx = 2'd0;
    old_idx  = 2'd0;
    for (int i = 2; i >= 0; i--) begin
      if (active_r[i] && (note_r[i] == note_q)) begin
        hit     = 1'b1;
        hit_idx = 2'(i);
      end
      if (!active_r[i]) begin
        free_any = 1'b1;
        free_idx = 2'(i);
      end
    end
    for (int i = 1; i < 3; i++) begin
      if (age_r[i] > age_r[old_idx]) old_idx = 2'(i);
    end

    if (!note_on_q || hit) tgt = hit_idx;
    else if (free_any)     tgt = free_idx;
    else                   tgt = old_idx;

    case (pan_mode)
      2'b01:   code = toggle_r ? 2'b01 : 2'b10;
      2'b10: begin
        case (tgt)
          2'd0:    code = 2'b10;
          2'd1:    code = 2'b11;
          default: code = 2'b01;
        endcase
      end
      default: code = 2'b11;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state       <= IDLE;
      note_ready  <= 1'b0;
      steal_pulse <= 1'b0;
      active_r    <= 3'b000;
      toggle_r    <= 1'b0;
      note_on_q   <= 1'b0;
      note_q      <= 7'd0;
      tgt_q       <= 2'd0;
      hit_q       <= 1'b0;
      steal_q     <= 1'b0;
      code_q      <= 2'b00;
      for (int i = 0; i < 3; i++) begin
        note_r[i] <= 7'd0;
        pan_r[i]  <= 2'b00;
        age_r[i]  <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          steal_pulse <= 1'b0;
          if (note_valid && note_ready) begin
            note_on_q  <= note_on;
            note_q     <= note_num;
            note_ready <= 1'b0;
            state      <= SEARCH;
          end else begin
            note_ready <= 1'b1;
          end
        end
        SEARCH: begin
          steal_pulse <= 1'b0;
          tgt_q       <= tgt;
          hit_q       <= hit;
          steal_q     <= note_on_q && !hit && !free_any;
          code_q      <= code;
          state       <= COMMIT;
        end
        COMMIT: begin
          if (note_on_q) begin
            for (int i = 0; i < 3; i++) begin
              if (2'(i) == tgt_q)
                age_r[i] <= '0;
              else if (active_r[i] && (age_r[i] != AGE_MAX))
                age_r[i] <= age_r[i] + AGE_ONE;
            end
            active_r[tgt_q] <= 1'b1;
            note_r[tgt_q]   <= note_q;
            // A retrigger keeps its pan code and does not advance the toggle.
            if (!hit_q) begin
              pan_r[tgt_q] <= code_q;
              toggle_r     <= ~toggle_r;
            end
            steal_pulse <= steal_q;
          end else if (hit_q) begin
            active_r[tgt_q] <= 1'b0;
            pan_r[tgt_q]    <= 2'b00;
            steal_pulse     <= 1'b0;
          end else begin
            steal_pulse <= 1'b0;
          end
          note_ready <= 1'b1;
          state      <= IDLE;
        end
        default: begin
          steal_pulse <= 1'b0;
          note_ready  <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

  assign voice_active = active_r;
  assign voice_note_a = note_r[0];
  assign voice_note_b = note_r[1];
  assign voice_note_c = note_r[2];
  assign stereo_a     = active_r[0] ? pan_r[0] : 2'b00;
  assign stereo_b     = active_r[1] ? pan_r[1] : 2'b00;
  assign stereo_c     = active_r[2] ? pan_r[2] : 2'b00;

endmodule
